neuron_column_sched: RTL and testbench
======================================

Name: neuron_column_sched

Overview:
- Time-multiplexes one shared combinational `neuron` datapath across NNEUR stored weight banks, forming a small column.
- Accepts one input spike volley through a valid/ready handshake, then evaluates each bank against that volley on successive cycles.
- Records which neurons fired, resolves a lowest-index winner (winner-take-all), and returns the result through a second valid/ready handshake.
- Sits between the input encoder and the column's WTA/STDP logic. The shared `neuron` instance lives outside this block.

Parameters:
- RF, `receptive_field (8): synapses per neuron, i.e. the spike volley width.
- WBITS, `WBITS (3): bits per weight.
- NNEUR, 4: number of weight banks (neurons) sharing the datapath. Must be at least 2.
- IDXW, $clog2(NNEUR): width of neuron index fields.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input volley present.
- in_ready  out  1  block can accept a volley.
- in_spikes  in  RF  input spike volley.
- wt_we  in  1  weight bank write strobe.
- wt_addr  in  IDXW  bank to write.
- wt_data  in  RF*WBITS  packed weights; slice [i*WBITS +: WBITS] is synapse i.
- nrn_spikes_in  out  RF  to the shared neuron's spikes_in.
- nrn_weights  out  RF*WBITS  to the shared neuron's weights.
- nrn_spike_out  in  1  shared neuron's spikes_out, combinational in the same cycle.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_fire  out  NNEUR  bit k set if neuron k fired.
- out_any  out  1  OR of out_fire.
- out_winner  out  IDXW  lowest k with out_fire[k] set; 0 if none fired.

Behaviour:
- Reset: state IDLE; all banks, the volley register, out_fire, out_winner, out_any and the index counter cleared to 0. out_valid=0, in_ready=0 while rst is high.
- States are IDLE, EVAL and DONE.
- IDLE:
  - in_ready = 1.
  - nrn_spikes_in = 0 and nrn_weights = 0.
  - When in_valid && in_ready: register in_spikes, clear out_fire, set idx=0, go to EVAL.
- EVAL:
  - in_ready = 0.
  - nrn_spikes_in = registered volley; nrn_weights = bank[idx].
  - Each clock, out_fire[idx] <= nrn_spike_out and idx <= idx+1.
  - When idx == NNEUR-1, go to DONE. EVAL lasts exactly NNEUR cycles.
- DONE:
  - out_valid = 1; out_fire, out_any and out_winner are stable.
  - nrn_* outputs driven to 0.
  - When out_ready is high, go to IDLE next cycle. out_valid holds until accepted.
- Latency: accept edge, then NNEUR EVAL cycles, then out_valid on the next cycle. Total NNEUR+1 cycles from accept to out_valid.
- Throughput: one volley per NNEUR+2 cycles when out_ready is tied high.
- out_winner and out_any are registered on the EVAL→DONE transition. They are not combinational from out_fire.
- Weight writes:
  - Honoured only in IDLE.
  - When wt_we is high in IDLE, bank[wt_addr] <= wt_data at the clock edge.
  - Writes in EVAL or DONE are silently dropped and banks are unchanged.
  - A write in the same cycle as a volley accept completes; EVAL, which starts next cycle, uses the new weights.
  - wt_addr >= NNEUR (non-power-of-2 NNEUR) is ignored.
- The block performs no arithmetic on weights; summation and threshold compare belong to the neuron.
- The index counter is IDXW bits wide and never wraps beyond NNEUR-1.
- rst asserted in EVAL or DONE aborts the volley: state goes to IDLE, the result is discarded, out_valid drops, and banks are cleared.
- in_valid while not in IDLE is ignored; the producer must hold the volley until in_ready.

Test Plan:
- Reset, then write nothing and send volley 8'hFF → out_valid after 5 cycles, out_fire=4'b0000, out_any=0, out_winner=0.
- Bench THRESHOLD=8 (other bench-neuron thresholds change expected values accordingly).
  - Write bank2 all weights 3'd7 (other banks zero); send 8'b0000_0011 (sum 14) → out_fire=4'b0100, out_winner=2, out_any=1.
  - Write bank1 and bank3 all 3'd7; send 8'b0000_0011 → out_fire=4'b1010, out_winner=1.
- Hold out_ready=0 for 6 cycles in DONE → out_valid and outputs stable, in_ready=0, and a wt_we to bank0 during the stall leaves bank0 unchanged (verify with a later volley).
- Same-cycle wt_we to bank0 (all 3'd7) and volley accept of 8'hFF → out_fire[0]=1.
- Assert rst for one cycle in the 2nd EVAL cycle → next cycle state IDLE, out_valid=0, in_ready=1. A subsequent 8'hFF volley yields out_fire=0 because banks were cleared.
- Back-to-back volleys with out_ready=1 → accepts spaced exactly NNEUR+2=6 cycles apart; nrn_weights equals bank0, bank1, bank2, bank3 on consecutive EVAL cycles.

Source files
------------

// File: rtl/neuron_column_sched.sv
// Scheduler that time-multiplexes one external neuron datapath across NNEUR
// weight banks, evaluating a captured spike volley bank by bank and reporting a lowest-index winner.
module neuron_column_sched #(
  parameter int RF    = 8,
  parameter int WBITS = 3,
  parameter int NNEUR = 4,
  parameter int IDXW  = $clog2(NNEUR)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [RF-1:0]         in_spikes,
  input  logic                  wt_we,
  input  logic [IDXW-1:0]       wt_addr,
  input  logic [RF*WBITS-1:0]   wt_data,
  output logic [RF-1:0]         nrn_spikes_in,
  output logic [RF*WBITS-1:0]   nrn_weights,
  input  logic                  nrn_spike_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NNEUR-1:0]      out_fire,
  output logic                  out_any,
  output logic [IDXW-1:0]       out_winner
);

  localparam int WW = RF * WBITS;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NNEUR - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EVAL,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [WW-1:0]     r_bank [NNEUR];
  logic [RF-1:0]     r_volley;
  logic [NNEUR-1:0]  r_fire;
  logic              r_any;
  logic [IDXW-1:0]   r_winner;
  logic [IDXW-1:0]   r_idx;

  logic              w_accept;
  logic              w_wt_ok;
  logic [NNEUR-1:0]  w_fire_eval;
  logic [IDXW-1:0]   w_winner;
  logic [WW-1:0]     w_bank_rd;

  assign w_accept  = (r_state == S_IDLE) && in_valid && !rst;
  assign w_wt_ok   = (r_state == S_IDLE) && wt_we && (int'(wt_addr) < NNEUR);
  assign w_bank_rd = r_bank[r_idx];

  // Fire vector as it will look after this EVAL edge, so the winner can be
  // registered on the same edge that records the last neuron.
  generate
    for (genvar gi = 0; gi < NNEUR; gi++) begin : g_fire
      assign w_fire_eval[gi] = (r_idx == IDXW'(gi)) ? nrn_spike_out : r_fire[gi];
    end
  endgenerate

  always_comb begin
    w_winner = '0;
    for (int k = NNEUR - 1; k >= 0; k--) begin
      if (w_fire_eval[k]) w_winner = IDXW'(k);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next  = r_state;
    in_ready      = 1'b0;
    out_valid     = 1'b0;
    nrn_spikes_in = '0;
    nrn_weights   = '0;
    case (r_state)
      S_IDLE: begin
        in_ready = !rst;
        if (w_accept) w_state_next = S_EVAL;
      end
      S_EVAL: begin
        nrn_spikes_in = r_volley;
        nrn_weights   = w_bank_rd;
        if (r_idx == IDX_LAST) w_state_next = S_DONE;
      end
      S_DONE: begin
        out_valid = !rst;
        if (out_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NNEUR; k++) r_bank[k] <= '0;
    end else if (w_wt_ok) begin
      r_bank[wt_addr] <= wt_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_volley <= '0;
      r_fire   <= '0;
      r_any    <= 1'b0;
      r_winner <= '0;
      r_idx    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_volley <= in_spikes;
            r_fire   <= '0;
            r_idx    <= '0;
          end
        end
        S_EVAL: begin
          r_fire <= w_fire_eval;
          if (r_idx == IDX_LAST) begin
            r_any    <= |w_fire_eval;
            r_winner <= w_winner;
          end else begin
            r_idx <= r_idx + IDXW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign out_fire   = r_fire;
  assign out_any    = r_any;
  assign out_winner = r_winner;

endmodule

// File: tb/tb_neuron_column_sched.sv
// Self-checking bench for neuron_column_sched: provides a threshold neuron,
// shadows the weight banks and scoreboards expected column results.
module tb_neuron_column_sched;

  localparam int RF = 8;
  localparam int WBITS = 3;
  localparam int NNEUR = 4;
  localparam int IDXW = 2;
  localparam int WW = RF * WBITS;
  localparam int THRESHOLD = 8;

  typedef struct packed {
    logic [NNEUR-1:0] fire;
    logic             any;
    logic [IDXW-1:0]  winner;
  } res_t;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [RF-1:0]     in_spikes;
  logic              wt_we;
  logic [IDXW-1:0]   wt_addr;
  logic [WW-1:0]     wt_data;
  logic [RF-1:0]     nrn_spikes_in;
  logic [WW-1:0]     nrn_weights;
  logic              nrn_spike_out;
  logic              out_valid;
  logic              out_ready;
  logic [NNEUR-1:0]  out_fire;
  logic              out_any;
  logic [IDXW-1:0]   out_winner;

  res_t          exp_q[$];
  logic [WW-1:0] sh_bank [NNEUR];
  int            checks = 0;
  int            failures = 0;

  neuron_column_sched #(.RF(RF), .WBITS(WBITS), .NNEUR(NNEUR)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_spikes(in_spikes),
    .wt_we(wt_we), .wt_addr(wt_addr), .wt_data(wt_data),
    .nrn_spikes_in(nrn_spikes_in), .nrn_weights(nrn_weights),
    .nrn_spike_out(nrn_spike_out),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_fire(out_fire), .out_any(out_any), .out_winner(out_winner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int wsum(input logic [RF-1:0] s, input logic [WW-1:0] w);
    int acc = 0;
    for (int i = 0; i < RF; i++) if (s[i]) acc += int'(w[i*WBITS +: WBITS]);
    return acc;
  endfunction

  // The shared neuron living outside the scheduler.
  always_comb nrn_spike_out = (wsum(nrn_spikes_in, nrn_weights) >= THRESHOLD);

  function automatic res_t predict(input logic [RF-1:0] v);
    res_t r;
    r.fire = '0;
    r.winner = '0;
    for (int k = 0; k < NNEUR; k++) r.fire[k] = (wsum(v, sh_bank[k]) >= THRESHOLD);
    for (int k = NNEUR - 1; k >= 0; k--) if (r.fire[k]) r.winner = IDXW'(k);
    r.any = |r.fire;
    return r;
  endfunction

  function automatic logic [WW-1:0] all_w(input int val);
    logic [WW-1:0] d;
    for (int i = 0; i < RF; i++) d[i*WBITS +: WBITS] = WBITS'(val);
    return d;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic write_bank(input int a, input logic [WW-1:0] d);
    wt_we = 1'b1;
    wt_addr = IDXW'(a);
    wt_data = d;
    tick();
    wt_we = 1'b0;
    if (a < NNEUR) sh_bank[a] = d;
  endtask

  task automatic wait_ready;
    int n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL wait_ready: in_ready=%b after %0d cycles, required 1", in_ready, n);
    end
  endtask

  task automatic send(input logic [RF-1:0] v);
    wait_ready();
    in_spikes = v;
    in_valid = 1'b1;
    exp_q.push_back(predict(v));
    tick();
    in_valid = 1'b0;
  endtask

  // Called right after the accept edge; consumes one result with out_ready high.
  task automatic collect(input string name);
    int lat = 1;
    res_t e;
    out_ready = 1'b1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    checks++;
    if (!out_valid || lat !== NNEUR + 1) begin
      failures++;
      $display("FAIL %s_latency: got %0d cycles (out_valid=%b), required %0d", name, lat, out_valid, NNEUR + 1);
    end
    if (out_valid && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (out_fire !== e.fire || out_any !== e.any || out_winner !== e.winner) begin
        failures++;
        $display("FAIL %s_result: got fire=%b any=%b winner=%0d, required fire=%b any=%b winner=%0d",
                 name, out_fire, out_any, out_winner, e.fire, e.any, e.winner);
      end
      $display("txn %s: fire=%b any=%b winner=%0d", name, out_fire, out_any, out_winner);
    end
    tick();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold: got in_ready=%b out_valid=%b, required 0 0", in_ready, out_valid);
    end
    tick();
    rst = 1'b0;
    for (int k = 0; k < NNEUR; k++) sh_bank[k] = '0;
    exp_q.delete();
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_fire !== '0 || out_any !== 1'b0 ||
        out_winner !== '0 || nrn_weights !== '0 || nrn_spikes_in !== '0) begin
      failures++;
      $display("FAIL reset_state: got rdy=%b vld=%b fire=%b any=%b win=%0d w=%h s=%h, required 1 0 0 0 0 0 0",
               in_ready, out_valid, out_fire, out_any, out_winner, nrn_weights, nrn_spikes_in);
    end
    $display("txn reset: in_ready=%b out_valid=%b", in_ready, out_valid);
  endtask

  task automatic test_zero_banks;
    send(8'hFF);
    collect("zero_banks");
  endtask

  task automatic test_fire_patterns;
    write_bank(2, all_w(7));
    send(8'b0000_0011);
    collect("single_bank2");
    write_bank(2, all_w(0));
    write_bank(1, all_w(7));
    write_bank(3, all_w(7));
    send(8'b0000_0011);
    collect("banks1_3");
  endtask

  task automatic test_stall;
    res_t e;
    int n = 0;
    send(8'b0000_0011);
    out_ready = 1'b0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    e = exp_q[0];
    for (int c = 0; c < 6; c++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_fire !== e.fire ||
          out_winner !== e.winner || out_any !== e.any) begin
        failures++;
        $display("FAIL stall_c%0d: got vld=%b rdy=%b fire=%b win=%0d any=%b, required 1 0 %b %0d %b",
                 c, out_valid, in_ready, out_fire, out_winner, out_any, e.fire, e.winner, e.any);
      end
      wt_we = (c == 2);
      wt_addr = '0;
      wt_data = all_w(7);
      tick();
      wt_we = 1'b0;
    end
    $display("txn stall: held %0d cycles fire=%b", 6, out_fire);
    out_ready = 1'b1;
    e = exp_q.pop_front();
    checks++;
    if (out_valid !== 1'b1 || out_fire !== e.fire) begin
      failures++;
      $display("FAIL stall_release: got vld=%b fire=%b, required 1 %b", out_valid, out_fire, e.fire);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL stall_drop: got out_valid=%b, required 0", out_valid);
    end
    send(8'hFF);
    collect("after_stall_write");
  endtask

  task automatic test_same_cycle_write;
    wait_ready();
    wt_we = 1'b1;
    wt_addr = '0;
    wt_data = all_w(7);
    sh_bank[0] = all_w(7);
    in_spikes = 8'hFF;
    in_valid = 1'b1;
    exp_q.push_back(predict(8'hFF));
    tick();
    wt_we = 1'b0;
    in_valid = 1'b0;
    collect("same_cycle_write");
  endtask

  task automatic test_abort;
    send(8'hFF);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    for (int k = 0; k < NNEUR; k++) sh_bank[k] = '0;
    exp_q.delete();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || nrn_weights !== '0) begin
      failures++;
      $display("FAIL abort_state: got vld=%b rdy=%b w=%h, required 0 1 0", out_valid, in_ready, nrn_weights);
    end
    $display("txn abort: out_valid=%b in_ready=%b", out_valid, in_ready);
    send(8'hFF);
    collect("after_abort");
  endtask

  task automatic test_back_to_back;
    logic [RF-1:0] vols [3];
    logic [RF-1:0] cur_vol;
    res_t e;
    int nacc = 0, nres = 0, cyc = 0, last_acc = -1, eval_k = -1;
    logic accepting;
    vols[0] = 8'hFF;
    vols[1] = 8'h03;
    vols[2] = 8'h0F;
    cur_vol = '0;
    for (int k = 0; k < NNEUR; k++) write_bank(k, all_w(k + 1));
    out_ready = 1'b1;
    wait_ready();
    in_spikes = vols[0];
    in_valid = 1'b1;
    while (nres < 3 && cyc < 60) begin
      if (eval_k >= 0) begin
        checks++;
        if (nrn_weights !== sh_bank[eval_k] || nrn_spikes_in !== cur_vol) begin
          failures++;
          $display("FAIL b2b_eval%0d: got w=%h s=%h, required w=%h s=%h",
                   eval_k, nrn_weights, nrn_spikes_in, sh_bank[eval_k], cur_vol);
        end
        eval_k++;
        if (eval_k == NNEUR) eval_k = -1;
      end
      if (out_valid && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (out_fire !== e.fire || out_any !== e.any || out_winner !== e.winner) begin
          failures++;
          $display("FAIL b2b_result%0d: got fire=%b any=%b win=%0d, required fire=%b any=%b win=%0d",
                   nres, out_fire, out_any, out_winner, e.fire, e.any, e.winner);
        end
        $display("txn b2b%0d: fire=%b any=%b winner=%0d", nres, out_fire, out_any, out_winner);
        nres++;
      end
      accepting = in_valid && in_ready;
      if (accepting) begin
        if (last_acc >= 0) begin
          checks++;
          if (cyc - last_acc !== NNEUR + 2) begin
            failures++;
            $display("FAIL b2b_spacing: got %0d cycles, required %0d", cyc - last_acc, NNEUR + 2);
          end
        end
        last_acc = cyc;
        cur_vol = in_spikes;
        exp_q.push_back(predict(in_spikes));
        nacc++;
      end
      tick();
      cyc++;
      if (accepting) begin
        eval_k = 0;
        if (nacc < 3) in_spikes = vols[nacc];
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (nres !== 3) begin
      failures++;
      $display("FAIL b2b_count: got %0d results, required 3", nres);
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_spikes = '0;
    wt_we = 1'b0;
    wt_addr = '0;
    wt_data = '0;
    out_ready = 1'b1;
    test_reset();
    test_zero_banks();
    test_fire_patterns();
    test_stall();
    test_same_cycle_write();
    test_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
